// File: rtl/alu_ctrl_muldiv.sv
// Execute-stage ALU control decoder with an iterative RV32M multiply/divide engine.
// Base ops decode combinationally; M ops stall the pipeline until result_valid pulses.
module alu_ctrl_muldiv #(
    parameter int unsigned XLEN      = 32,
    parameter bit          FAST_MUL  = 1'b0,
    parameter int unsigned ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           alu_op_in,
    input  logic [6:0]           func7,
    input  logic [2:0]           func3,
    input  logic                 start,
    input  logic                 kill,
    input  logic [XLEN-1:0]      rs1,
    input  logic [XLEN-1:0]      rs2,
    output logic [ALUCTRL_W-1:0] alu_control_out,
    output logic                 is_muldiv,
    output logic                 stall,
    output logic [XLEN-1:0]      result,
    output logic                 result_valid
);
    localparam int unsigned W2    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [W2-1:0]    acc, acc_nxt;
    logic [XLEN-1:0]  div_b;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ctrl;

    logic             a_sgn, b_sgn, is_div, div_zero, div_ovf, single, launch, neg_flag;
    logic [XLEN-1:0]  mag_a, mag_b, single_res, final_res, div_sel;
    logic [W2-1:0]    prod_fast, prod_sgn, mul_final;
    logic [XLEN:0]    mul_sum, div_sh, div_trial;

    always_comb begin
        ctrl = 4'b0000;
        case (alu_op_in)
            2'b00: ctrl = 4'b0010;
            2'b01: begin
                case (func3)
                    3'b000:  ctrl = 4'b0110;
                    3'b001:  ctrl = 4'b1011;
                    3'b100:  ctrl = 4'b1100;
                    3'b101:  ctrl = 4'b1101;
                    3'b110:  ctrl = 4'b1110;
                    3'b111:  ctrl = 4'b1111;
                    default: ;
                endcase
            end
            2'b10: begin
                if (func7 == F7_BASE) begin
                    case (func3)
                        3'b000:  ctrl = 4'b0010;
                        3'b111:  ctrl = 4'b0000;
                        3'b110:  ctrl = 4'b0001;
                        3'b100:  ctrl = 4'b0011;
                        3'b001:  ctrl = 4'b1000;
                        3'b101:  ctrl = 4'b1001;
                        default: ;
                    endcase
                end else if (func7 == F7_ALT) begin
                    case (func3)
                        3'b000:  ctrl = 4'b0110;
                        3'b101:  ctrl = 4'b1010;
                        default: ;
                    endcase
                end
            end
            default: begin
                case (func3)
                    3'b000: ctrl = 4'b0010;
                    3'b111: ctrl = 4'b0000;
                    3'b110: ctrl = 4'b0001;
                    3'b100: ctrl = 4'b0011;
                    3'b001: if (func7 == F7_BASE) ctrl = 4'b1000;
                    3'b101: begin
                        if (func7 == F7_BASE)     ctrl = 4'b1001;
                        else if (func7 == F7_ALT) ctrl = 4'b1010;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    assign alu_control_out = ALUCTRL_W'(ctrl);
    assign is_muldiv       = (alu_op_in == 2'b10) && (func7 == F7_MULDIV);

    // Operand magnitudes, result sign and the results that bypass CALC.
    always_comb begin
        is_div = func3[2];
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_sgn = rs1[XLEN-1];
                b_sgn = rs2[XLEN-1];
            end
            3'b010:  a_sgn = rs1[XLEN-1];
            default: ;
        endcase
        mag_a    = a_sgn ? -rs1 : rs1;
        mag_b    = b_sgn ? -rs2 : rs2;
        neg_flag = (is_div && func3[1]) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero = is_div && (rs2 == '0);
        div_ovf  = is_div && !func3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        prod_fast = W2'(mag_a) * W2'(mag_b);
        prod_sgn  = (a_sgn ^ b_sgn) ? -prod_fast : prod_fast;
        if (is_div)
            single_res = div_zero ? (func3[1] ? rs1 : '1) : (func3[1] ? '0 : rs1);
        else
            single_res = (func3[1:0] == 2'b00) ? prod_sgn[XLEN-1:0] : prod_sgn[W2-1:XLEN];
        single = div_zero || div_ovf || (FAST_MUL && !is_div);
        launch = start && is_muldiv && !kill;
    end

    // acc holds {hi, lo}: product accumulator / multiplier for MUL, remainder / quotient for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, div_b} : '0);
        div_sh    = acc[W2-1:XLEN-1];
        div_trial = div_sh - {1'b0, div_b};
        if (op_q[2]) begin
            if (div_trial[XLEN]) acc_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else                 acc_nxt = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
        mul_final = neg_q ? -acc_nxt : acc_nxt;
        div_sel   = op_q[1] ? acc_nxt[W2-1:XLEN] : acc_nxt[XLEN-1:0];
        if (op_q[2])
            final_res = neg_q ? -div_sel : div_sel;
        else
            final_res = (op_q[1:0] == 2'b00) ? mul_final[XLEN-1:0] : mul_final[W2-1:XLEN];
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = start && is_muldiv;
                if (launch) state_nxt = single ? DONE : CALC;
            end
            CALC: begin
                stall = 1'b1;
                if (kill)                            state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            div_b  <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && launch) begin
                op_q  <= func3;
                neg_q <= neg_flag;
                div_b <= mag_b;
                acc   <= {{XLEN{1'b0}}, mag_a};
                cnt   <= '0;
                if (single) result <= single_res;
            end else if (state == CALC && !kill) begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(XLEN - 1)) result <= final_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Bench for alu_ctrl_muldiv: directed decode and special cases, kill/reset aborts,
// and randomized M-operations checked against a 64-bit integer reference model.
module tb_alu_ctrl_muldiv;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n, start, start_f, kill;
    logic [1:0]  alu_op_in;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2;
    logic [3:0]  alu_control_out, alu_control_out_f;
    logic        is_muldiv, is_muldiv_f, stall, stall_f, result_valid, result_valid_f;
    logic [31:0] result, result_f;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [2:0]  r_f3;
    logic [31:0] r_a, r_b;
    bit          seen;

    always #5 clk = ~clk;

    alu_ctrl_muldiv #(.XLEN(XLEN), .FAST_MUL(1'b0), .ALUCTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op_in(alu_op_in), .func7(func7), .func3(func3),
        .start(start), .kill(kill), .rs1(rs1), .rs2(rs2),
        .alu_control_out(alu_control_out), .is_muldiv(is_muldiv), .stall(stall),
        .result(result), .result_valid(result_valid)
    );

    alu_ctrl_muldiv #(.XLEN(XLEN), .FAST_MUL(1'b1), .ALUCTRL_W(4)) dut_f (
        .clk(clk), .rst_n(rst_n), .alu_op_in(alu_op_in), .func7(func7), .func3(func3),
        .start(start_f), .kill(kill), .rs1(rs1), .rs2(rs2),
        .alu_control_out(alu_control_out_f), .is_muldiv(is_muldiv_f), .stall(stall_f),
        .result(result_f), .result_valid(result_valid_f)
    );

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like RV32M.
    function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        r  = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: if (b == 32'h0) r = '1; else begin p = sa / sb; r = p[31:0]; end
            3'd5: if (b == 32'h0) r = '1; else begin p = ua / ub; r = p[31:0]; end
            3'd6: if (b == 32'h0) r = a;  else begin p = sa % sb; r = p[31:0]; end
            default: if (b == 32'h0) r = a; else begin p = ua % ub; r = p[31:0]; end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input bit fast, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return fast ? 1 : XLEN + 1;
        if (b == 32'h0) return 1;
        if (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic run_op(input string tag, input bit fast, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        int          exp_lat, lat;
        bit          stall_held;
        exp_res = ref_muldiv(f3, a, b);
        exp_lat = ref_latency(fast, f3, a, b);
        alu_op_in = 2'b10; func7 = 7'b0000001; func3 = f3; rs1 = a; rs2 = b;
        if (fast) start_f = 1'b1; else start = 1'b1;
        #1;
        check_bit($sformatf("%s stall@0", tag), fast ? stall_f : stall, 1'b1);
        lat = 0;
        stall_held = 1'b1;
        do begin
            @(posedge clk); #1;
            start = 1'b0; start_f = 1'b0;
            lat++;
            if (!(fast ? result_valid_f : result_valid) && !(fast ? stall_f : stall))
                stall_held = 1'b0;
        end while (!(fast ? result_valid_f : result_valid) && lat < 100);
        check_int($sformatf("%s latency", tag), lat, exp_lat);
        check_word($sformatf("%s result", tag), fast ? result_f : result, exp_res);
        check_bit($sformatf("%s stall@valid", tag), fast ? stall_f : stall, 1'b0);
        check_bit($sformatf("%s stall held", tag), stall_held, 1'b1);
        @(posedge clk); #1;
        check_bit($sformatf("%s valid pulse", tag), fast ? result_valid_f : result_valid, 1'b0);
    endtask

    task automatic chk_dec(input string tag, input logic [1:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [3:0] exp_ctrl, input logic exp_md);
        alu_op_in = op; func7 = f7; func3 = f3;
        start = !exp_md;
        #1;
        check_word($sformatf("%s ctrl", tag), 32'(alu_control_out), 32'(exp_ctrl));
        check_word($sformatf("%s ctrl fast", tag), 32'(alu_control_out_f), 32'(exp_ctrl));
        check_bit($sformatf("%s is_muldiv", tag), is_muldiv, exp_md);
        check_bit($sformatf("%s is_muldiv fast", tag), is_muldiv_f, exp_md);
        check_bit($sformatf("%s stall", tag), stall, 1'b0);
        @(posedge clk); #1;
        check_bit($sformatf("%s no valid", tag), result_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_f = 1'b0; kill = 1'b0;
        alu_op_in = '0; func7 = '0; func3 = '0; rs1 = '0; rs2 = '0;
        #2;
        check_word("reset result", result, 32'h0);
        check_bit("reset valid", result_valid, 1'b0);
        check_bit("reset stall", stall, 1'b0);
        check_word("reset result fast", result_f, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk_dec("SRA",      2'b10, 7'b0100000, 3'b101, 4'b1010, 1'b0);
        chk_dec("BR110",    2'b01, 7'b0000000, 3'b110, 4'b1110, 1'b0);
        chk_dec("ADDI f7",  2'b11, 7'b0100000, 3'b000, 4'b0010, 1'b0);
        chk_dec("LDST",     2'b00, 7'b1111111, 3'b111, 4'b0010, 1'b0);
        chk_dec("SLL",      2'b10, 7'b0000000, 3'b001, 4'b1000, 1'b0);
        chk_dec("OR",       2'b10, 7'b0000000, 3'b110, 4'b0001, 1'b0);
        chk_dec("SUB",      2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0);
        chk_dec("SRLI",     2'b11, 7'b0000000, 3'b101, 4'b1001, 1'b0);
        chk_dec("SRAI",     2'b11, 7'b0100000, 3'b101, 4'b1010, 1'b0);
        chk_dec("SLLI bad", 2'b11, 7'b0100000, 3'b001, 4'b0000, 1'b0);
        chk_dec("R bad",    2'b10, 7'b0100000, 3'b001, 4'b0000, 1'b0);
        chk_dec("BR bad",   2'b01, 7'b0000000, 3'b010, 4'b0000, 1'b0);
        chk_dec("XORI f7",  2'b11, 7'b1010101, 3'b100, 4'b0011, 1'b0);
        chk_dec("MULHU",    2'b10, 7'b0000001, 3'b011, 4'b0000, 1'b1);
        start = 1'b0;

        run_op("MUL",   1'b0, 3'd0, 32'hFFFF_FFFF, 32'd3);
        run_op("MULH",  1'b0, 3'd1, 32'hFFFF_FFFF, 32'd3);
        run_op("MULHU", 1'b0, 3'd3, 32'hFFFF_FFFF, 32'd3);
        run_op("DIV",   1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("REM",   1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("DIVU",  1'b0, 3'd5, 32'd100, 32'd7);
        run_op("REMU",  1'b0, 3'd7, 32'd100, 32'd7);
        run_op("DIVU0", 1'b0, 3'd5, 32'h1234, 32'h0);
        run_op("REM0",  1'b0, 3'd6, 32'h1234, 32'h0);
        run_op("DIVOV", 1'b0, 3'd4, INT_MIN, 32'hFFFF_FFFF);
        run_op("REMOV", 1'b0, 3'd6, INT_MIN, 32'hFFFF_FFFF);

        // kill during cycle 10 of a DIV
        alu_op_in = 2'b10; func7 = 7'b0000001; func3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        check_bit("kill stall@10", stall, 1'b1);
        @(posedge clk); #1 kill = 1'b0;
        check_bit("kill stall@11", stall, 1'b0);
        check_bit("kill valid@11", result_valid, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid || stall) seen = 1'b1;
        end
        check_bit("kill no valid", seen, 1'b0);
        run_op("MUL6x7", 1'b0, 3'd0, 32'd6, 32'd7);

        // asynchronous reset in the middle of cycle 5 of a MUL
        alu_op_in = 2'b10; func7 = 7'b0000001; func3 = 3'd0; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_bit("arst stall", stall, 1'b0);
        check_bit("arst valid", result_valid, 1'b0);
        check_word("arst result", result, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid || stall) seen = 1'b1;
        end
        check_bit("arst idle after release", seen, 1'b0);
        run_op("MULHU post-reset", 1'b0, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678);

        run_op("FAST MULHSU", 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);

        for (int i = 0; i < 24; i++) begin
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'h0;
                1: r_b = 32'($urandom_range(1, 15));
                2: begin r_a = INT_MIN; r_b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op($sformatf("rnd%0d f3=%0d", i, r_f3), 1'b0, r_f3, r_a, r_b);
        end

        for (int i = 0; i < 10; i++) begin
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            run_op($sformatf("frnd%0d f3=%0d", i, r_f3), 1'b1, r_f3, r_a, r_b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
- Parametrised successor of the single-cycle ALU control decoder.
- Decodes {ALUOp, funct7, funct3} into the 4-bit ALU control code for base RV32I operations.
- Adds the RV32M multiply/divide operations, executed by an iterative multi-cycle engine with a start/stall/done handshake.
- Sits in the execute stage beside the main ALU; its stall output freezes PC and pipeline registers while an M-operation is in flight.

Parameters:
XLEN, 32, operand/result width (must be even, >=8)
FAST_MUL, 0, 1 = multiply completes combinationally in one cycle; 0 = one bit per cycle
ALUCTRL_W, 4, width of ALU control code

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_op_in  input  2  ALUOp from main control
func7  input  7  instruction funct7
func3  input  3  instruction funct3
start  input  1  execute stage holds a valid instruction this cycle
kill  input  1  flush; aborts any M-operation in progress
rs1  input  XLEN  operand A
rs2  input  XLEN  operand B
alu_control_out  output  ALUCTRL_W  ALU code for non-M operations (combinational)
is_muldiv  output  1  decoded instruction is RV32M (combinational)
stall  output  1  hold pipeline; M-result not yet available
result  output  XLEN  M-operation result, valid with result_valid
result_valid  output  1  one-cycle pulse; result is valid

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; result, internal accumulators and counter cleared to 0; result_valid=0, stall=0.
- Decode (combinational, no latency):
  - ALUOp 00 -> 0010.
  - ALUOp 01: funct3 000/001/100/101/110/111 -> 0110/1011/1100/1101/1110/1111.
  - ALUOp 10, funct7 0000000: ADD 0010, AND 0000, OR 0001, XOR 0011, SLL 1000, SRL 1001.
  - ALUOp 10, funct7 0100000: SUB 0110, SRA 1010.
  - ALUOp 11: SLLI/SRLI/SRAI by funct7 as above; ADDI/ANDI/ORI/XORI by funct3 with funct7 ignored.
  - All other codes -> 0000.
- M decode: is_muldiv=1 iff alu_op_in=10 and func7=0000001. alu_control_out is then 0000.
  - funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, CALC, DONE:
  - IDLE: on start && is_muldiv && !kill, latch op, rs1, rs2 and signs; go to CALC (or DONE for the single-cycle cases below).
  - stall = start && is_muldiv in IDLE (combinational), and 1 throughout CALC.
  - CALC: process one bit per cycle, counter 0..XLEN-1; after XLEN cycles go to DONE.
  - Multiply: shift-add on 2*XLEN product of magnitudes; sign correction applied at the end. Signed/unsigned per op: MULHSU treats rs1 signed, rs2 unsigned.
  - Divide: restoring division on magnitudes. Quotient sign = sign(rs1) xor sign(rs2); remainder takes sign(rs1).
  - DONE: result registered, result_valid=1 and stall=0 for exactly one cycle; return to IDLE.
- Latency from the start cycle (cycle 0) to result_valid:
  - Iterative MUL*/DIV*/REM*: cycle XLEN+1.
  - FAST_MUL=1 multiplies: cycle 1.
  - Special division cases: cycle 1, skipping CALC.
- Special division cases:
  - Divide by zero: DIV/DIVU quotient all-ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = -1): DIV result = rs1; REM result = 0.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
- start while in CALC or DONE is ignored; the pipeline is stalled, so start must not re-trigger.
- kill has priority over start and over CALC progress: next state IDLE; no result_valid; stall drops the cycle after kill.
- Non-M instructions never leave IDLE and never assert stall.
- Reset mid-operation aborts immediately; no result_valid after reset release.

Test Plan:
- Decode sweep: ALUOp=10/f7=0100000/f3=101 -> alu_control_out=1010, is_muldiv=0, stall=0; ALUOp=01/f3=110 -> 1110; ALUOp=11/f7=0100000/f3=000 -> 0010.
- MUL, XLEN=32, FAST_MUL=0: rs1=0xFFFFFFFF, rs2=3 -> stall high for cycles 0..32, result_valid at cycle 33, result=0xFFFFFFFD; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000002.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> result 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special cases: DIVU x/0 with rs1=0x1234 -> 0xFFFFFFFF at cycle 1; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM same -> 0.
- kill asserted at cycle 10 of a DIV -> FSM IDLE at cycle 11, stall=0, no result_valid; a following MUL 6*7 completes normally with result 42.
- Async reset: rst_n low at cycle 5 of a MUL, between clock edges -> stall and result_valid 0 immediately; after release, start ignored until asserted again; FAST_MUL=1 build: MULHSU rs1=-1, rs2=2 -> result 0xFFFFFFFF at cycle 1.
